parking_occupancy_manager: RTL and testbench

Sequential stage downstream of the exit decoder. It consumes the one-hot exit location produced from a 3-bit park number, and it also serves entry requests.
- Holds the 8-spot occupancy register.
- Allocates the lowest-index free spot on entry and releases the indicated spot on exit.
- Drives a timed gate-open pulse and reports free count and full/empty status to the display and gate logic.

---
 rtl/parking_pkg.sv | 33 +++
 rtl/free_spot_finder.sv | 22 ++
 rtl/parking_occupancy_manager.sv | 173 +++++++++++++++++
 tb/tb_parking_occupancy_manager.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking occupancy manager and its helpers.
package parking_pkg;

  localparam int N_SPOTS          = 8;
  localparam int IDX_W            = 3;
  localparam int CNT_W            = 4;
  localparam int GATE_CYCLES_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_EXIT  = 2'd2,
    ST_GATE  = 2'd3
  } state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [N_SPOTS-1:0] v);
    logic [N_SPOTS-1:0] one;
    one = {{(N_SPOTS-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

  // Number of set bits, sized for the free-count output.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_SPOTS-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < N_SPOTS; i++) begin
      sum = sum + CNT_W'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/free_spot_finder.sv
// Lowest-index free spot search over the occupancy vector.
module free_spot_finder
  import parking_pkg::*;
(
  input  logic [N_SPOTS-1:0] occupancy,
  output logic [IDX_W-1:0]   spot_idx,
  output logic               found
);

  // Scan from the top down so the last hit, and therefore the winner, is the lowest index.
  always_comb begin
    found    = 1'b0;
    spot_idx = '0;
    for (int i = N_SPOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        found    = 1'b1;
        spot_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_occupancy_manager.sv
// Parking lot occupancy register with entry allocation, exit release and timed gate.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; exit wins over a simultaneous entry
// ST_ENTER | allocate lowest free spot or reject when the lot is full
// ST_EXIT  | release the latched spot or flag a bad location
// ST_GATE  | gate held open while the counter runs down; requests ignored
module parking_occupancy_manager
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter_req,
  input  logic               exit_req,
  input  logic [N_SPOTS-1:0] exit_location,
  output logic               enter_ack,
  output logic [IDX_W-1:0]   enter_park_number,
  output logic               enter_reject,
  output logic               exit_ack,
  output logic               exit_error,
  output logic               gate_open,
  output logic               busy,
  output logic [N_SPOTS-1:0] occupancy,
  output logic [CNT_W-1:0]   free_count,
  output logic               full,
  output logic               empty
);

  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPOTS_CNT = CNT_W'(N_SPOTS);

  state_e             state_q, state_d;
  logic [N_SPOTS-1:0] occ_q, occ_d;
  logic [N_SPOTS-1:0] loc_q, loc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   park_q, park_d;
  logic               enter_ack_q, enter_ack_d;
  logic               enter_rej_q, enter_rej_d;
  logic               exit_ack_q, exit_ack_d;
  logic               exit_err_q, exit_err_d;
  logic               gate_q, gate_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   free_q, free_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  logic [IDX_W-1:0]   free_idx;
  logic               free_found;
  logic               exit_ok;

  free_spot_finder u_finder (
    .occupancy (occ_q),
    .spot_idx  (free_idx),
    .found     (free_found)
  );

  assign exit_ok = is_one_hot(loc_q) && ((loc_q & occ_q) != '0);

  // State and registered outputs; reset aborts anything in flight, including the gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      occ_q       <= '0;
      loc_q       <= '0;
      cnt_q       <= '0;
      park_q      <= '0;
      enter_ack_q <= 1'b0;
      enter_rej_q <= 1'b0;
      exit_ack_q  <= 1'b0;
      exit_err_q  <= 1'b0;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      free_q      <= SPOTS_CNT;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      loc_q       <= loc_d;
      cnt_q       <= cnt_d;
      park_q      <= park_d;
      enter_ack_q <= enter_ack_d;
      enter_rej_q <= enter_rej_d;
      exit_ack_q  <= exit_ack_d;
      exit_err_q  <= exit_err_d;
      gate_q      <= gate_d;
      busy_q      <= busy_d;
      free_q      <= free_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exit_req)       state_d = ST_EXIT;
        else if (enter_req) state_d = ST_ENTER;
      end
      ST_ENTER: state_d = free_found ? ST_GATE : ST_IDLE;
      ST_EXIT:  state_d = exit_ok ? ST_GATE : ST_IDLE;
      ST_GATE:  if (cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; status flags derive from the next occupancy
  // so they always agree with the occupancy register in the same cycle.
  always_comb begin
    occ_d       = occ_q;
    loc_d       = loc_q;
    cnt_d       = cnt_q;
    park_d      = park_q;
    enter_ack_d = 1'b0;
    enter_rej_d = 1'b0;
    exit_ack_d  = 1'b0;
    exit_err_d  = 1'b0;
    gate_d      = gate_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exit_req) loc_d = exit_location;
      end
      ST_ENTER: begin
        if (free_found) begin
          occ_d       = occ_q | (N_SPOTS'(1) << free_idx);
          park_d      = free_idx;
          enter_ack_d = 1'b1;
          cnt_d       = GATE_LOAD;
          gate_d      = 1'b1;
        end else begin
          enter_rej_d = 1'b1;
        end
      end
      ST_EXIT: begin
        if (exit_ok) begin
          occ_d      = occ_q & ~loc_q;
          exit_ack_d = 1'b1;
          cnt_d      = GATE_LOAD;
          gate_d     = 1'b1;
        end else begin
          exit_err_d = 1'b1;
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) gate_d = 1'b0;
        else             cnt_d  = cnt_q - 1'b1;
      end
      default: ;
    endcase
    busy_d  = (state_d != ST_IDLE);
    free_d  = SPOTS_CNT - popcount(occ_d);
    full_d  = &occ_d;
    empty_d = ~|occ_d;
  end

  assign enter_ack         = enter_ack_q;
  assign enter_park_number = park_q;
  assign enter_reject      = enter_rej_q;
  assign exit_ack          = exit_ack_q;
  assign exit_error        = exit_err_q;
  assign gate_open         = gate_q;
  assign busy              = busy_q;
  assign occupancy         = occ_q;
  assign free_count        = free_q;
  assign full              = full_q;
  assign empty             = empty_q;

endmodule

// File: tb/tb_parking_occupancy_manager.sv
// Scoreboard bench for parking_occupancy_manager with a set-of-spots reference model.
module tb_parking_occupancy_manager;

  localparam int GATE = 4;

  // response kinds
  localparam int K_ENTER_ACK = 0;
  localparam int K_REJECT    = 1;
  localparam int K_EXIT_ACK  = 2;
  localparam int K_EXIT_ERR  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enter_req, exit_req;
  logic [7:0] exit_location;
  logic       enter_ack, enter_reject, exit_ack, exit_error;
  logic [2:0] enter_park_number;
  logic       gate_open, busy, full, empty;
  logic [7:0] occupancy;
  logic [3:0] free_count;

  always #5 clk = ~clk;

  parking_occupancy_manager #(.GATE_CYCLES(GATE)) dut (
    .clk               (clk),
    .rst               (rst),
    .enter_req         (enter_req),
    .exit_req          (exit_req),
    .exit_location     (exit_location),
    .enter_ack         (enter_ack),
    .enter_park_number (enter_park_number),
    .enter_reject      (enter_reject),
    .exit_ack          (exit_ack),
    .exit_error        (exit_error),
    .gate_open         (gate_open),
    .busy              (busy),
    .occupancy         (occupancy),
    .free_count        (free_count),
    .full              (full),
    .empty             (empty)
  );

  typedef struct {
    int         kind;
    int         num;
    logic [7:0] occ;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  bit         spot_taken[8];
  bit         skip_gate = 1'b0;
  int         gate_run  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model_occ();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = spot_taken[i];
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) spot_taken[i] = 1'b0;
  endfunction

  // Entry: take the smallest unused spot, or reject when every spot is taken.
  function automatic void push_enter();
    exp_t e;
    e.kind = K_REJECT;
    e.num  = 0;
    for (int i = 0; i < 8; i++) begin
      if (e.kind == K_REJECT && !spot_taken[i]) begin
        e.kind        = K_ENTER_ACK;
        e.num         = i;
        spot_taken[i] = 1'b1;
      end
    end
    e.occ = model_occ();
    sb.push_back(e);
  endfunction

  // Exit: accepted only for a single named spot that is currently taken.
  function automatic void push_exit(input logic [7:0] loc);
    exp_t e;
    int   ones, which;
    ones  = 0;
    which = 0;
    for (int i = 0; i < 8; i++) if (loc[i]) begin ones++; which = i; end
    e.num = 0;
    if (ones == 1 && spot_taken[which]) begin
      spot_taken[which] = 1'b0;
      e.kind = K_EXIT_ACK;
    end else begin
      e.kind = K_EXIT_ERR;
    end
    e.occ = model_occ();
    sb.push_back(e);
  endfunction

  // Monitor: pop an expectation whenever a response pulse appears; track gate width.
  always @(negedge clk) begin
    exp_t e;
    int   k, n, ones;
    if (!rst) begin
      n = int'(enter_ack) + int'(enter_reject) + int'(exit_ack) + int'(exit_error);
      if (n != 0) begin
        if (n > 1)             k = 7;
        else if (enter_ack)    k = K_ENTER_ACK;
        else if (enter_reject) k = K_REJECT;
        else if (exit_ack)     k = K_EXIT_ACK;
        else                   k = K_EXIT_ERR;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_response: got kind %0d expected none at %0t", k, $time);
        end else begin
          e = sb.pop_front();
          ones = 0;
          for (int i = 0; i < 8; i++) ones += int'(e.occ[i]);
          chk("resp_kind", k, e.kind);
          if (e.kind == K_ENTER_ACK) chk("park_number", enter_park_number, e.num);
          chk("occupancy", occupancy, e.occ);
          chk("free_count", free_count, 8 - ones);
          chk("full", full, ones == 8);
          chk("empty", empty, ones == 0);
          chk("gate_at_resp", gate_open, e.kind == K_ENTER_ACK || e.kind == K_EXIT_ACK);
          chk("busy_at_resp", busy, e.kind == K_ENTER_ACK || e.kind == K_EXIT_ACK);
        end
      end
      if (gate_open) begin
        gate_run++;
      end else if (gate_run > 0) begin
        if (!skip_gate) chk("gate_width", gate_run, GATE);
        gate_run  = 0;
        skip_gate = 1'b0;
      end
    end else begin
      gate_run = 0;
    end
  end

  // Hold the request(s) until answered, then wait for the FSM to return to idle.
  task automatic do_req(input bit en, input bit ex, input logic [7:0] loc);
    int waited;
    @(negedge clk);
    if (ex) push_exit(loc);
    if (en) push_enter();
    enter_req     = en;
    exit_req      = ex;
    exit_location = loc;
    waited = 0;
    while ((enter_req || exit_req) && waited < 40) begin
      @(negedge clk);
      waited++;
      if (exit_req && (exit_ack || exit_error))      exit_req  = 1'b0;
      if (enter_req && (enter_ack || enter_reject))  enter_req = 1'b0;
    end
    if (enter_req || exit_req) begin
      total++;
      bad++;
      $display("FAIL response_timeout: got no response expected one within 40 cycles");
      enter_req = 1'b0;
      exit_req  = 1'b0;
    end
    waited = 0;
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy=1 expected 0 within 40 cycles");
    end
  endtask

  initial begin
    int          r;
    int          waited;
    logic [7:0]  loc;

    rst           = 1'b1;
    enter_req     = 1'b0;
    exit_req      = 1'b0;
    exit_location = 8'h00;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    chk("reset_occupancy", occupancy, 8'h00);
    chk("reset_free_count", free_count, 8);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_gate_open", gate_open, 0);
    chk("reset_busy", busy, 0);
    chk("reset_park_number", enter_park_number, 0);

    // Fill the lot, then one more entry must be rejected.
    for (int i = 0; i < 9; i++) do_req(1'b1, 1'b0, 8'h00);
    chk("full_occupancy", occupancy, 8'hFF);
    chk("full_free_count", free_count, 0);

    // Release spot 3, then the next entry must land there.
    do_req(1'b0, 1'b1, 8'b0000_1000);
    do_req(1'b1, 1'b0, 8'h00);

    // Bad exits: no spot, two spots, a spot that is free.
    do_req(1'b0, 1'b1, 8'b0000_0000);
    do_req(1'b0, 1'b1, 8'b0000_0011);
    do_req(1'b0, 1'b1, 8'b0100_0000);
    do_req(1'b0, 1'b1, 8'b0100_0000);
    chk("after_errors_occupancy", occupancy, 8'hBF);

    // Simultaneous exit of spot 5 and an entry: exit first, then entry reuses 5.
    do_req(1'b1, 1'b1, 8'b0010_0000);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        do_req(1'b1, 1'b0, 8'h00);
      end else if (r <= 6) begin
        loc = 8'h01 << $urandom_range(0, 7);
        do_req(1'b0, 1'b1, loc);
      end else if (r == 7) begin
        loc = 8'($urandom());
        do_req(1'b0, 1'b1, loc);
      end else begin
        loc = 8'h01 << $urandom_range(0, 7);
        do_req(1'b1, 1'b1, loc);
      end
    end

    // Reset during the second gate cycle aborts the gate and clears the lot.
    do_req(1'b0, 1'b1, model_occ() & (~model_occ() + 8'h01));
    @(negedge clk);
    push_enter();
    enter_req = 1'b1;
    waited = 0;
    while (enter_req && waited < 40) begin
      @(negedge clk);
      waited++;
      if (enter_ack || enter_reject) enter_req = 1'b0;
    end
    if (enter_req) begin
      total++;
      bad++;
      $display("FAIL reset_setup_timeout: got no response expected one within 40 cycles");
      enter_req = 1'b0;
    end
    @(negedge clk);
    skip_gate = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    chk("abort_gate_open", gate_open, 0);
    chk("abort_busy", busy, 0);
    chk("abort_occupancy", occupancy, 8'h00);
    chk("abort_free_count", free_count, 8);
    rst = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    skip_gate = 1'b0;
    do_req(1'b1, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
